// File: rtl/pipe_stage_hs_if.sv
// Valid/ready handshake bundle carrying one pipeline item:
// instruction word, payload and control bits.
// The master drives the item and valid; the slave answers with ready.
interface pipe_stage_hs_if #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 8
);
  logic              valid;
  logic              ready;
  logic [15:0]       instr;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (
    output valid,
    output instr,
    output data,
    output ctrl,
    input  ready
  );

  modport slave (
    input  valid,
    input  instr,
    input  data,
    input  ctrl,
    output ready
  );
endinterface

// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: inter-stage pipeline register with valid/ready handshake,
// flush and bubble masking.
// An empty slot shows NOP_INSTR and all-zero control downstream, so no
// side effect of a stale item can leak.
// bubble_cnt saturates and counts every edge where downstream was ready
// but the stage had nothing to give.
// Build option PIPE_SKID_EN: adds a second (skid) slot so that in_ready is
// a registered signal with no combinational path from out_ready.
// Without it the stage holds a single slot and in_ready depends on out_ready.
module pipe_stage_hs #(
  parameter int          DATA_W    = 16,
  parameter int          CTRL_W    = 8,
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter int          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  pipe_stage_hs_if.slave    in_bus,
  pipe_stage_hs_if.master   out_bus,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    r = (&v) ? v : v + 1'b1;
    return r;
  endfunction

  // Main slot: the item presented downstream.
  logic              vld_p0;
  logic [15:0]       instr_p0;
  logic [DATA_W-1:0] data_p0;
  logic [CTRL_W-1:0] ctrl_p0;

  logic ready_int;
  logic xfer_in;
  logic xfer_out;
  logic load_main_in;

  assign xfer_in      = in_bus.valid & ready_int;
  assign xfer_out     = vld_p0 & out_bus.ready;
  assign in_bus.ready = ready_int;

`ifdef PIPE_SKID_EN
  // Skid slot: catches the item accepted while main is stalled.
  logic              vld_p1;
  logic [15:0]       instr_p1;
  logic [DATA_W-1:0] data_p1;
  logic [CTRL_W-1:0] ctrl_p1;

  logic load_main_skid;
  logic load_skid;

  // Ready only depends on skid occupancy (a flop) and the squash input.
  assign ready_int = !vld_p1 & !flush;

  // Decide where this edge's moves go: input to main, skid to main, or input to skid.
  always_comb begin
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (!flush) begin
      if (!vld_p0) begin
        load_main_in = xfer_in;
      end else if (xfer_out) begin
        if (vld_p1) begin
          load_main_skid = 1'b1;
        end else begin
          load_main_in = xfer_in;
        end
      end else begin
        load_skid = xfer_in;
      end
    end
  end

  // Slot occupancy; flush empties both slots, reset overrides everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (flush) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= load_main_in | load_main_skid | (vld_p0 & !xfer_out);
      vld_p1 <= load_skid | (vld_p1 & !load_main_skid);
    end
  end

  // Main payload; cleared by reset so out_data reads zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_p0 <= '0;
      data_p0  <= '0;
      ctrl_p0  <= '0;
    end else if (load_main_in) begin
      instr_p0 <= in_bus.instr;
      data_p0  <= in_bus.data;
      ctrl_p0  <= in_bus.ctrl;
    end else if (load_main_skid) begin
      instr_p0 <= instr_p1;
      data_p0  <= data_p1;
      ctrl_p0  <= ctrl_p1;
    end
  end

  // Skid payload; never visible while empty, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      instr_p1 <= in_bus.instr;
      data_p1  <= in_bus.data;
      ctrl_p1  <= in_bus.ctrl;
    end
  end
`else
  // Single slot: accept when empty or when the held item leaves this edge.
  assign ready_int    = (!vld_p0 | out_bus.ready) & !flush;
  assign load_main_in = xfer_in;

  // Slot occupancy; a transfer-in overrides a same-edge transfer-out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
    end else if (flush) begin
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= load_main_in | (vld_p0 & !xfer_out);
    end
  end

  // Main payload; cleared by reset so out_data reads zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_p0 <= '0;
      data_p0  <= '0;
      ctrl_p0  <= '0;
    end else if (load_main_in) begin
      instr_p0 <= in_bus.instr;
      data_p0  <= in_bus.data;
      ctrl_p0  <= in_bus.ctrl;
    end
  end
`endif

  // Bubble counter: downstream ready with nothing valid on offer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (out_bus.ready && !vld_p0) begin
      bubble_cnt <= sat_inc(bubble_cnt);
    end
  end

  // Empty slot masks instruction to NOP and control to zero; data is left unmasked.
  assign out_bus.valid = vld_p0;
  assign out_bus.instr = vld_p0 ? instr_p0 : NOP_INSTR;
  assign out_bus.ctrl  = vld_p0 ? ctrl_p0 : '0;
  assign out_bus.data  = data_p0;

endmodule
